// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed seven-segment display driver.
// Hex font is active-low {g,f,e,d,c,b,a} in bits [6:0]; bit 7 (dp) is held dark.
package seg7_pkg;
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam logic [15:0][7:0] HEX_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/seg7_decode.sv
// Hex value to active-low seven-segment pattern (no decimal point).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);
    logic [7:0] glyph;

    assign glyph = HEX_FONT[value];
    assign seg   = glyph[6:0];
endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit common-anode scan driver with PWM brightness, decimal points,
// leading-zero blanking and frame-aligned capture of the displayed values.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 6250,
    parameter int CNT_W    = 13
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [3:0] Digit3,
    input  logic [3:0] Digit2,
    input  logic [3:0] Digit1,
    input  logic [3:0] Digit0,
    input  logic [3:0] DpMask,
    input  logic [3:0] Brightness,
    input  logic       BlankLead,
    output logic [3:0] SegmentDrivers,
    output logic [7:0] SevenSegment
);
    logic [CNT_W-1:0] prescale;
    logic [3:0]       phase;
    digit_idx_t       idx;
    logic             first;
    logic [3:0][3:0]  sh_dig;
    logic [3:0]       sh_dp;
    logic             sh_bl;

    logic             tick, slot_end, frame_end;
    logic [3:0][3:0]  in_dig, cur_dig;
    logic [3:0]       cur_dp, blank;
    logic             cur_bl, lit;
    logic [6:0]       seg_pat;

    assign tick      = (prescale == CNT_W'(SCAN_DIV - 1));
    assign slot_end  = tick && (phase == 4'hF);
    assign frame_end = slot_end && (idx == 2'd3);
    assign in_dig    = {Digit3, Digit2, Digit1, Digit0};

    // The first cycle after reset shows the live inputs while they are being captured.
    assign cur_dig = first ? in_dig    : sh_dig;
    assign cur_dp  = first ? DpMask    : sh_dp;
    assign cur_bl  = first ? BlankLead : sh_bl;

    assign blank[3] = cur_bl && (cur_dig[3] == 4'd0);
    assign blank[2] = blank[3] && (cur_dig[2] == 4'd0);
    assign blank[1] = blank[2] && (cur_dig[1] == 4'd0);
    assign blank[0] = 1'b0;

    assign lit = (phase <= Brightness) && !blank[idx];

    seg7_decode u_dec (
        .value (cur_dig[idx]),
        .seg   (seg_pat)
    );

    always_ff @(posedge CLK100MHZ or posedge Reset) begin
        if (Reset) begin
            prescale       <= '0;
            phase          <= '0;
            idx            <= '0;
            first          <= 1'b1;
            sh_dig         <= '0;
            sh_dp          <= '0;
            sh_bl          <= 1'b0;
            SegmentDrivers <= ANODE_OFF;
            SevenSegment   <= SEG_OFF;
        end else begin
            prescale <= tick ? '0 : prescale + CNT_W'(1);
            if (tick)     phase <= phase + 4'd1;
            if (slot_end) idx   <= idx + 2'd1;
            first <= 1'b0;
            if (first || frame_end) begin
                sh_dig <= in_dig;
                sh_dp  <= DpMask;
                sh_bl  <= BlankLead;
            end
            // Anodes and cathodes update on the same edge so no digit ghosts.
            if (lit) begin
                SegmentDrivers <= ~(4'b0001 << idx);
                SevenSegment   <= {~cur_dp[idx], seg_pat};
            end else begin
                SegmentDrivers <= ANODE_OFF;
                SevenSegment   <= SEG_OFF;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=2 (slot 32 cycles, frame 128).
// Every cycle's pins are compared against a timing model via a scoreboard queue.
module tb_seg7_scan_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d3, d2, d1, d0, dpm, br;
    logic       bl;
    logic [3:0] an;
    logic [7:0] seg;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(2), .CNT_W(2)) dut (
        .CLK100MHZ      (clk),
        .Reset          (rst),
        .Digit3         (d3),
        .Digit2         (d2),
        .Digit1         (d1),
        .Digit0         (d0),
        .DpMask         (dpm),
        .Brightness     (br),
        .BlankLead      (bl),
        .SegmentDrivers (an),
        .SevenSegment   (seg)
    );

    localparam logic [7:0] FONT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int          checks = 0;
    int          errors = 0;
    int          t = 0;
    int          c;
    logic [11:0] sbq[$];
    logic [3:0]  m_d[4];
    logic [3:0]  m_dp;
    logic        m_bl;

    function automatic logic [11:0] expect_at(int tt, logic [3:0] br_now);
        int         slot = (tt / 32) % 4;
        int         ph   = (tt / 2) % 16;
        logic       blank;
        logic [7:0] g;
        logic [3:0] a;
        blank = (slot == 3 && m_bl && m_d[3] == 0) ||
                (slot == 2 && m_bl && m_d[3] == 0 && m_d[2] == 0) ||
                (slot == 1 && m_bl && m_d[3] == 0 && m_d[2] == 0 && m_d[1] == 0);
        if (ph <= int'(br_now) && !blank) begin
            g = FONT[m_d[slot]];
            a = 4'hF;
            a[slot] = 1'b0;
            return {a, ~m_dp[slot], g[6:0]};
        end
        return 12'hFFF;
    endfunction

    task automatic capture();
        m_d[3] = d3; m_d[2] = d2; m_d[1] = d1; m_d[0] = d0;
        m_dp = dpm;
        m_bl = bl;
    endtask

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d obs=%h exp=%h", tag, t, obs, exp);
        end
    endtask

    // One clock: predict the pins for this edge, then compare 1 ns later.
    task automatic step();
        @(posedge clk);
        if (t == 0) capture();
        sbq.push_back(expect_at(t, br));
        if (t % 128 == 127) capture();
        #1;
        check("scan", {an, seg}, sbq.pop_front());
        t++;
    endtask

    task automatic run_to(int target);
        while (t <= target) step();
    endtask

    initial begin
        rst = 1'b1;
        d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
        dpm = 4'b0000; br = 4'd15; bl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", {an, seg}, 12'hFFF);
        rst = 1'b0;

        run_to(5);
        check("slot0_d4", {an, seg}, {4'b1110, 8'h99});
        run_to(100);
        check("slot3_d1", {an, seg}, {4'b0111, 8'hF9});

        // PWM duty, Digit0 change lands at frame 1
        br = 4'd3; d0 = 4'd8;
        run_to(127);
        c = 0;
        repeat (32) begin step(); if (!an[0]) c++; end
        check("pwm_b3", 12'(c), 12'd8);
        br = 4'd15;
        run_to(255);
        c = 0;
        repeat (32) begin step(); if (!an[0]) c++; end
        check("pwm_b15", 12'(c), 12'd32);

        // leading-zero blanking, digits 0,0,0,5 in frame 3
        bl = 1'b1; d3 = 4'd0; d2 = 4'd0; d1 = 4'd0; d0 = 4'd5;
        run_to(390);
        check("blank_d0", {an, seg}, {4'b1110, 8'h92});
        c = 0;
        while (t <= 511) begin step(); if (an[3:1] != 3'b111) c++; end
        check("blank_321", 12'(c), 12'd0);

        // digits 0,7,0,0 in frame 5: only digit3 dark
        d3 = 4'd0; d2 = 4'd7; d1 = 4'd0; d0 = 4'd0;
        run_to(680);
        check("blank_d1_zero", {an, seg}, {4'b1101, 8'hC0});
        c = 0;
        while (t <= 767) begin step(); if (!an[3]) c++; end
        check("blank_d3", 12'(c), 12'd0);

        // decimal point on digit2 in frame 7
        bl = 1'b0; d3 = 4'd0; d2 = 4'd2; d1 = 4'd0; d0 = 4'd0; dpm = 4'b0100;
        run_to(970);
        check("dp_d2", {an, seg}, {4'b1011, 8'h24});
        run_to(1023);

        // mid-frame change must not tear frame 9
        dpm = 4'b0000; d3 = 4'd1; d2 = 4'd2; d1 = 4'd3; d0 = 4'd4;
        run_to(1160);
        d1 = 4'd9;
        run_to(1190);
        check("no_tear", {an, seg}, {4'b1101, 8'hB0});
        run_to(1320);
        check("next_frame", {an, seg}, {4'b1101, 8'h90});

        // asynchronous reset mid slot 2
        run_to(1350);
        rst = 1'b1;
        #1;
        check("rst_async", {an, seg}, 12'hFFF);
        d3 = 4'd5; d2 = 4'd6; d1 = 4'd7; d0 = 4'd8;
        @(posedge clk);
        #1;
        check("rst_held_edge", {an, seg}, 12'hFFF);
        rst = 1'b0;
        sbq.delete();
        t = 0;
        run_to(5);
        check("rst_slot0", {an, seg}, {4'b1110, 8'h80});
        run_to(100);
        check("rst_slot3", {an, seg}, {4'b0111, 8'h92});
        run_to(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
